// File: rtl/imem_loader.sv
// Boot loader: takes a framed byte stream, writes 32-bit words into instruction memory,
// verifies a payload checksum and releases the cpu from reset on success.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    StIdle, StCntLo, StCntHi, StData, StCsum, StDone, StError
  } state_e;

  localparam int unsigned CntW     = ADDR_WIDTH + 1;
  localparam logic [16:0] Capacity = 17'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [31:0]           word_q, word_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic accept;
  logic last_word;

  assign in_ready  = (state_q != StDone);
  assign accept    = in_valid && in_ready;
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, count_q};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_cnt_d   = word_cnt_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    case (state_q)
      StIdle, StError: begin
        if (accept && (in_data == MAGIC)) begin
          state_d      = StCntLo;
          load_error_d = 1'b0;
          count_d      = '0;
          word_cnt_d   = '0;
          byte_idx_d   = '0;
          csum_d       = '0;
        end
      end
      StCntLo: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = StCntHi;
        end
      end
      StCntHi: begin
        if (accept) begin
          count_d[15:8] = in_data;
          // Oversize images are rejected before any write so addresses never wrap.
          if ({1'b0, in_data, count_q[7:0]} > Capacity) begin
            state_d      = StError;
            load_error_d = 1'b1;
          end else if ({in_data, count_q[7:0]} == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d     = {in_data, word_q[31:8]};
          csum_d     = csum_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            imem_wdata_d = {in_data, word_q[31:8]};
            word_cnt_d   = word_cnt_q + 1'b1;
            if (last_word) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d     = StDone;
            cpu_reset_d = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d      = StError;
            load_error_d = 1'b1;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule
